// File: rtl/dbg_display_pkg.sv
// Shared page codes, snapshot record and page-advance helper for the debug display front end.
package dbg_display_pkg;

  localparam int SEL_W = 3;

  typedef logic [SEL_W-1:0] page_t;

  localparam page_t PAGE_INSTR_LO = 3'd0;
  localparam page_t PAGE_INSTR_HI = 3'd1;
  localparam page_t PAGE_PC_LO    = 3'd2;
  localparam page_t PAGE_PC_HI    = 3'd3;
  localparam page_t PAGE_ALU_LO   = 3'd4;
  localparam page_t PAGE_ALU_HI   = 3'd5;
  localparam page_t PAGE_LAST     = PAGE_ALU_HI;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] alu;
  } dbg_snap_t;

  function automatic page_t next_page(page_t p);
    return (p == PAGE_LAST) ? PAGE_INSTR_LO : p + 3'd1;
  endfunction

endpackage

// File: rtl/dbg_display_if.sv
// Board/pipeline side bundle of the debug display front end.
interface dbg_display_if;
  import dbg_display_pkg::*;

  logic        btn_next;
  logic        btn_freeze;
  logic        wb_valid;
  logic [31:0] instruction_in;
  logic [31:0] pc_in;
  logic [31:0] alu_in;
  logic [31:0] instruction;
  logic [31:0] pc_out;
  logic [31:0] alu_out;
  page_t       sel;
  logic        frozen;

  modport master (
    output btn_next, btn_freeze, wb_valid, instruction_in, pc_in, alu_in,
    input  instruction, pc_out, alu_out, sel, frozen
  );

  modport slave (
    input  btn_next, btn_freeze, wb_valid, instruction_in, pc_in, alu_in,
    output instruction, pc_out, alu_out, sel, frozen
  );

endinterface

// File: rtl/dbg_debounce.sv
// Push-button conditioner: 2-FF synchronizer, stable-count debouncer and rising-edge pulse.
module dbg_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic pulse_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q;
  logic          db_q, db_d, db_prev_q;
  logic [CW-1:0] cnt_q, cnt_d;

  // Any return to agreement restarts the count, so bounces never accumulate.
  always_comb begin
    db_d  = db_q;
    cnt_d = '0;
    if (sync_q[1] != db_q) begin
      if (cnt_q == CNT_MAX) db_d = sync_q[1];
      else                  cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q    <= '0;
      db_q      <= 1'b0;
      db_prev_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      sync_q    <= {sync_q[0], btn_i};
      db_q      <= db_d;
      db_prev_q <= db_q;
      cnt_q     <= cnt_d;
    end
  end

  assign pulse_o = db_q & ~db_prev_q;

endmodule

// File: rtl/dbg_display_ctrl.sv
// Debug display front end: snapshot hold registers, page select and freeze control.
// Optional DBG_AUTO_CYCLE_EN adds a free-running page auto-advance.
module dbg_display_ctrl
  import dbg_display_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int AUTO_PERIOD     = 100_000_000
) (
  input  logic         clk,
  input  logic         reset,
  dbg_display_if.slave bus
);

  logic      next_pulse, frz_pulse, auto_pulse, adv;
  page_t     sel_q, sel_d;
  logic      frozen_q, frozen_d;
  dbg_snap_t snap_q, snap_d;
  logic      cap_en;

  dbg_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_next (
    .clk    (clk),
    .reset  (reset),
    .btn_i  (bus.btn_next),
    .pulse_o(next_pulse)
  );

  dbg_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_freeze (
    .clk    (clk),
    .reset  (reset),
    .btn_i  (bus.btn_freeze),
    .pulse_o(frz_pulse)
  );

`ifdef DBG_AUTO_CYCLE_EN
  localparam int AW = $clog2(AUTO_PERIOD);
  localparam logic [AW-1:0] AUTO_MAX = AW'(AUTO_PERIOD - 1);

  logic [AW-1:0] auto_q, auto_d;

  assign auto_pulse = (auto_q == AUTO_MAX) && !frozen_q;

  always_comb begin
    auto_d = auto_q + 1'b1;
    if (frozen_q || next_pulse || auto_pulse) auto_d = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) auto_q <= '0;
    else       auto_q <= auto_d;
  end
`else
  logic unused_auto;
  assign unused_auto = |AUTO_PERIOD;
  assign auto_pulse  = 1'b0;
`endif

  // OR keeps a coincident manual and auto advance to a single step.
  assign adv = next_pulse | auto_pulse;

  // A freeze pulse on a capture edge wins: capture only if neither frozen nor freezing.
  assign cap_en = bus.wb_valid && !frozen_q && !frz_pulse;

  always_comb begin
    sel_d    = adv ? next_page(sel_q) : sel_q;
    frozen_d = frz_pulse ? ~frozen_q : frozen_q;
    snap_d   = snap_q;
    if (cap_en) snap_d = '{instr: bus.instruction_in, pc: bus.pc_in, alu: bus.alu_in};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel_q    <= PAGE_INSTR_LO;
      frozen_q <= 1'b0;
      snap_q   <= '0;
    end else begin
      sel_q    <= sel_d;
      frozen_q <= frozen_d;
      snap_q   <= snap_d;
    end
  end

  assign bus.sel         = sel_q;
  assign bus.frozen      = frozen_q;
  assign bus.instruction = snap_q.instr;
  assign bus.pc_out      = snap_q.pc;
  assign bus.alu_out     = snap_q.alu;

endmodule

// File: tb/tb_dbg_display_ctrl.sv
// Directed bench for dbg_display_ctrl with DEBOUNCE_CYCLES=4, AUTO_PERIOD=20.
module tb_dbg_display_ctrl;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  dbg_display_if bus ();

  dbg_display_ctrl #(.DEBOUNCE_CYCLES(4), .AUTO_PERIOD(20)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press_freeze();
    bus.btn_freeze = 1'b1;
    cyc(10);
    bus.btn_freeze = 1'b0;
    cyc(10);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.btn_next = 1'b0; bus.btn_freeze = 1'b0; bus.wb_valid = 1'b0;
    bus.instruction_in = '0; bus.pc_in = '0; bus.alu_in = '0;
    #1;
    checks++;
    if ({bus.sel, bus.frozen} !== 4'b0) begin
      errors++; $display("FAIL reset_sel_frozen: got %b %b want 000 0", bus.sel, bus.frozen);
    end
    checks++;
    if ({bus.instruction, bus.pc_out, bus.alu_out} !== 96'b0) begin
      errors++; $display("FAIL reset_hold: got %h %h %h want zeros", bus.instruction, bus.pc_out, bus.alu_out);
    end
    cyc(2);
    reset = 1'b0;
  endtask

  task automatic test_no_auto();
    logic [2:0] s;
    s = bus.sel;
    cyc(50);
    checks++;
    if (bus.sel !== s) begin
      errors++; $display("FAIL idle_sel: got %0d want %0d", bus.sel, s);
    end
  endtask

  task automatic test_page_wrap();
    logic [2:0] prev, exp;
    for (int i = 0; i < 6; i++) begin
      prev = bus.sel;
      exp  = 3'((i + 1) % 6);
      bus.btn_next = 1'b1;
      cyc(6);
      checks++;
      if (bus.sel !== prev) begin
        errors++; $display("FAIL wrap_early%0d: got %0d want %0d", i, bus.sel, prev);
      end
      cyc(1);
      checks++;
      if (bus.sel !== exp) begin
        errors++; $display("FAIL wrap_step%0d: got %0d want %0d", i, bus.sel, exp);
      end
      cyc(3);
      bus.btn_next = 1'b0;
      cyc(10);
    end
  endtask

  task automatic test_bounce();
    logic [2:0] s, exp;
    s = bus.sel;
    for (int i = 0; i < 5; i++) begin
      bus.btn_next = 1'b1; cyc(2);
      bus.btn_next = 1'b0; cyc(2);
    end
    cyc(10);
    checks++;
    if (bus.sel !== s) begin
      errors++; $display("FAIL bounce_ignored: got %0d want %0d", bus.sel, s);
    end
    exp = (s == 3'd5) ? 3'd0 : s + 3'd1;
    bus.btn_next = 1'b1; cyc(10);
    bus.btn_next = 1'b0; cyc(20);
    checks++;
    if (bus.sel !== exp) begin
      errors++; $display("FAIL bounce_clean_press: got %0d want %0d", bus.sel, exp);
    end
  endtask

  task automatic test_capture_freeze();
    bus.wb_valid = 1'b1;
    bus.instruction_in = 32'h12345678; bus.pc_in = 32'hABCDEF01; bus.alu_in = 32'h87654321;
    cyc(1);
    bus.wb_valid = 1'b0;
    checks++;
    if ({bus.instruction, bus.pc_out, bus.alu_out} !== {32'h12345678, 32'hABCDEF01, 32'h87654321}) begin
      errors++; $display("FAIL capture: got %h %h %h want 12345678 abcdef01 87654321",
                         bus.instruction, bus.pc_out, bus.alu_out);
    end
    bus.instruction_in = 32'h0BADF00D; bus.pc_in = 32'h0BADF00D; bus.alu_in = 32'h0BADF00D;
    cyc(2);
    checks++;
    if (bus.instruction !== 32'h12345678) begin
      errors++; $display("FAIL capture_novalid: got %h want 12345678", bus.instruction);
    end
    press_freeze();
    checks++;
    if (bus.frozen !== 1'b1) begin
      errors++; $display("FAIL freeze_on: got %b want 1", bus.frozen);
    end
    bus.wb_valid = 1'b1;
    bus.instruction_in = 32'h11111111; bus.pc_in = 32'h22222222; bus.alu_in = 32'h33333333;
    cyc(3);
    bus.wb_valid = 1'b0;
    checks++;
    if ({bus.instruction, bus.pc_out, bus.alu_out} !== {32'h12345678, 32'hABCDEF01, 32'h87654321}) begin
      errors++; $display("FAIL frozen_hold: got %h %h %h want 12345678 abcdef01 87654321",
                         bus.instruction, bus.pc_out, bus.alu_out);
    end
    press_freeze();
    checks++;
    if (bus.frozen !== 1'b0) begin
      errors++; $display("FAIL freeze_off: got %b want 0", bus.frozen);
    end
    bus.wb_valid = 1'b1;
    cyc(1);
    bus.wb_valid = 1'b0;
    checks++;
    if ({bus.instruction, bus.pc_out, bus.alu_out} !== {32'h11111111, 32'h22222222, 32'h33333333}) begin
      errors++; $display("FAIL unfrozen_capture: got %h %h %h want 11111111 22222222 33333333",
                         bus.instruction, bus.pc_out, bus.alu_out);
    end
  endtask

  task automatic test_coincidence();
    bus.btn_freeze = 1'b1;
    cyc(6);
    bus.wb_valid = 1'b1; bus.instruction_in = 32'hDEADBEEF;
    cyc(1);
    bus.wb_valid = 1'b0;
    checks++;
    if (bus.instruction !== 32'h11111111 || bus.frozen !== 1'b1) begin
      errors++; $display("FAIL coincide_freeze: got %h %b want 11111111 1", bus.instruction, bus.frozen);
    end
    cyc(3);
    bus.btn_freeze = 1'b0;
    cyc(10);
    // Unfreeze edge itself does not capture; the following edge does.
    bus.btn_freeze = 1'b1;
    cyc(6);
    bus.wb_valid = 1'b1; bus.instruction_in = 32'hCAFEF00D;
    cyc(1);
    checks++;
    if (bus.instruction !== 32'h11111111 || bus.frozen !== 1'b0) begin
      errors++; $display("FAIL coincide_unfreeze: got %h %b want 11111111 0", bus.instruction, bus.frozen);
    end
    cyc(1);
    bus.wb_valid = 1'b0;
    checks++;
    if (bus.instruction !== 32'hCAFEF00D) begin
      errors++; $display("FAIL resume_capture: got %h want cafef00d", bus.instruction);
    end
    cyc(2);
    bus.btn_freeze = 1'b0;
    cyc(10);
  endtask

  task automatic test_reset_mid();
    press_freeze();
    bus.btn_next = 1'b1;
    cyc(3);
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({bus.sel, bus.frozen} !== 4'b0 ||
        {bus.instruction, bus.pc_out, bus.alu_out} !== 96'b0) begin
      errors++; $display("FAIL reset_mid: got sel %0d frz %b %h %h %h want all zero",
                         bus.sel, bus.frozen, bus.instruction, bus.pc_out, bus.alu_out);
    end
    cyc(2);
    reset = 1'b0;
    cyc(6);
    checks++;
    if (bus.sel !== 3'd0) begin
      errors++; $display("FAIL held_early: got %0d want 0", bus.sel);
    end
    cyc(1);
    checks++;
    if (bus.sel !== 3'd1) begin
      errors++; $display("FAIL held_accept: got %0d want 1", bus.sel);
    end
    bus.btn_next = 1'b0;
    cyc(10);
    checks++;
    if (bus.sel !== 3'd1 || bus.frozen !== 1'b0) begin
      errors++; $display("FAIL held_once: got %0d %b want 1 0", bus.sel, bus.frozen);
    end
  endtask

  task automatic test_auto();
    logic [2:0] s, exp;
    cyc(19);
    checks++;
    if (bus.sel !== 3'd0) begin
      errors++; $display("FAIL auto_early: got %0d want 0", bus.sel);
    end
    cyc(1);
    checks++;
    if (bus.sel !== 3'd1) begin
      errors++; $display("FAIL auto_step1: got %0d want 1", bus.sel);
    end
    cyc(19);
    checks++;
    if (bus.sel !== 3'd1) begin
      errors++; $display("FAIL auto_hold: got %0d want 1", bus.sel);
    end
    cyc(1);
    checks++;
    if (bus.sel !== 3'd2) begin
      errors++; $display("FAIL auto_step2: got %0d want 2", bus.sel);
    end
    bus.btn_freeze = 1'b1;
    cyc(7);
    bus.btn_freeze = 1'b0;
    s = bus.sel;
    cyc(60);
    checks++;
    if (bus.sel !== s || bus.frozen !== 1'b1) begin
      errors++; $display("FAIL auto_frozen: got %0d %b want %0d 1", bus.sel, bus.frozen, s);
    end
    bus.btn_freeze = 1'b1;
    cyc(7);
    bus.btn_freeze = 1'b0;
    cyc(19);
    checks++;
    if (bus.sel !== s || bus.frozen !== 1'b0) begin
      errors++; $display("FAIL auto_restart_early: got %0d %b want %0d 0", bus.sel, bus.frozen, s);
    end
    cyc(1);
    exp = (s == 3'd5) ? 3'd0 : s + 3'd1;
    checks++;
    if (bus.sel !== exp) begin
      errors++; $display("FAIL auto_restart: got %0d want %0d", bus.sel, exp);
    end
  endtask

  initial begin
    test_reset();
`ifdef DBG_AUTO_CYCLE_EN
    test_auto();
`else
    test_no_auto();
    test_page_wrap();
    test_bounce();
    test_capture_freeze();
    test_coincidence();
    test_reset_mid();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
